// File: rtl/nms_window_gen.sv
// 3x3 sliding-window generator for non-maximum suppression over a raster gradient stream.
// Define NMS_WIN_REPLICATE_EN for edge replication at borders; the default is zero padding.
module nms_window_gen #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] pix_in,
  input  logic       dir_in,
  output logic [7:0] p00,
  output logic [7:0] p01,
  output logic [7:0] p02,
  output logic [7:0] p10,
  output logic [7:0] p11,
  output logic [7:0] p12,
  output logic [7:0] p20,
  output logic [7:0] p21,
  output logic [7:0] p22,
  output logic       grad_dir,
  output logic       win_valid,
  output logic       frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = $clog2(IMG_W + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(IMG_W);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_c, out_c;
  logic [RW-1:0] in_r, out_r;
  logic [FW-1:0] fl_cnt;

  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];
  logic       dlb1 [IMG_W];
  logic [7:0] sr  [3][2];
  logic       dsr_c;
  logic [7:0] win [3][3];
  logic [7:0] msk [3][3];
  logic [7:0] pw  [3][3];

  logic ready_ok, flushing, accept, step, primed, emit, last_pix, dx;
  logic [7:0] px;

  assign ready_ok = rst && ((state == IDLE) || (state == RUN));
  assign in_ready = ready_ok;
  assign flushing = (state == FLUSH);
  assign accept   = in_valid && ready_ok;
  assign step     = accept || flushing;
  // Pixel index >= IMG_W+1 means the window centred one row and one column back is complete.
  assign primed   = (in_r != '0) && !((in_r == RW'(1)) && (in_c == '0));
  assign emit     = (accept && primed) || flushing;
  assign last_pix = (in_r == R_LAST) && (in_c == C_LAST);
  assign px       = flushing ? 8'h00 : pix_in;
  assign dx       = flushing ? 1'b0 : dir_in;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_pix ? FLUSH : RUN;
      RUN:     if (accept && last_pix) state_nxt = FLUSH;
      FLUSH:   if (fl_cnt == FL_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Columns 0..1 come from the shift register, column 2 is the column arriving this cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win[i][0] = sr[i][0];
      win[i][1] = sr[i][1];
    end
    win[0][2] = lb2[in_c];
    win[1][2] = lb1[in_c];
    win[2][2] = px;
    msk = win;
`ifdef NMS_WIN_REPLICATE_EN
    if (out_r == '0)    for (int j = 0; j < 3; j++) msk[0][j] = win[1][j];
    if (out_r == R_LAST) for (int j = 0; j < 3; j++) msk[2][j] = win[1][j];
    if (out_c == '0)    for (int i = 0; i < 3; i++) msk[i][0] = msk[i][1];
    if (out_c == C_LAST) for (int i = 0; i < 3; i++) msk[i][2] = msk[i][1];
`else
    if (out_r == '0)    for (int j = 0; j < 3; j++) msk[0][j] = 8'h00;
    if (out_r == R_LAST) for (int j = 0; j < 3; j++) msk[2][j] = 8'h00;
    if (out_c == '0)    for (int i = 0; i < 3; i++) msk[i][0] = 8'h00;
    if (out_c == C_LAST) for (int i = 0; i < 3; i++) msk[i][2] = 8'h00;
`endif
  end

  // Storage that border masking keeps from ever reaching the outputs stale, so it has no reset.
  always_ff @(posedge clk) begin
    if (step) begin
      lb1[in_c]  <= px;
      lb2[in_c]  <= lb1[in_c];
      dlb1[in_c] <= dx;
      dsr_c      <= dlb1[in_c];
      for (int i = 0; i < 3; i++) begin
        sr[i][0] <= sr[i][1];
        sr[i][1] <= win[i][2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      in_r       <= '0;
      in_c       <= '0;
      out_r      <= '0;
      out_c      <= '0;
      fl_cnt     <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      grad_dir   <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          pw[i][j] <= 8'h00;
    end else begin
      state      <= state_nxt;
      win_valid  <= emit;
      frame_done <= flushing && (fl_cnt == FL_LAST);
      fl_cnt     <= flushing ? fl_cnt + 1'b1 : '0;
      if (state == DONE) begin
        in_r <= '0;
        in_c <= '0;
      end else if (step) begin
        if (in_c == C_LAST) begin
          in_c <= '0;
          in_r <= (in_r == R_LAST) ? '0 : in_r + 1'b1;
        end else begin
          in_c <= in_c + 1'b1;
        end
      end
      if (emit) begin
        pw       <= msk;
        grad_dir <= dsr_c;
        if (out_c == C_LAST) begin
          out_c <= '0;
          out_r <= (out_r == R_LAST) ? '0 : out_r + 1'b1;
        end else begin
          out_c <= out_c + 1'b1;
        end
      end
    end
  end

  assign p00 = pw[0][0];
  assign p01 = pw[0][1];
  assign p02 = pw[0][2];
  assign p10 = pw[1][0];
  assign p11 = pw[1][1];
  assign p12 = pw[1][2];
  assign p20 = pw[2][0];
  assign p21 = pw[2][1];
  assign p22 = pw[2][2];

endmodule

// File: tb/tb_nms_window_gen.sv
// Self-checking bench for nms_window_gen on a 4x3 frame: fixed window table, gapped stream,
// constant frame, mid-frame reset and random frames against a coordinate-based window model.
module tb_nms_window_gen;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, dir_in;
  logic [7:0] pix_in;
  logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic       grad_dir, win_valid, frame_done;

  always #5 clk = ~clk;

  nms_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pix_in(pix_in), .dir_in(dir_in),
    .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
    .p20(p20), .p21(p21), .p22(p22),
    .grad_dir(grad_dir), .win_valid(win_valid), .frame_done(frame_done)
  );

  typedef struct {
    int         k;
    logic [8:0][7:0] p;
    logic       d;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: frame image as accepted, phase 0 accepting, 1 flushing, 2 done cycle.
  logic [7:0] img  [N];
  logic       dimg [N];
  int ph, acc, fl, next_k;

  // Observations of the DUT for the current run.
  logic [7:0] cap  [N][9];
  logic       capd [N];
  int cap_n, done_n, first_acc, acc_total, low_n;

  vec_t tbl [5];

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int k, int a0, int a1, int a2, int a3, int a4,
                              int a5, int a6, int a7, int a8, logic d);
    vec_t v;
    v.k = k;
    v.p[0] = 8'(a0); v.p[1] = 8'(a1); v.p[2] = 8'(a2);
    v.p[3] = 8'(a3); v.p[4] = 8'(a4); v.p[5] = 8'(a5);
    v.p[6] = 8'(a6); v.p[7] = 8'(a7); v.p[8] = 8'(a8);
    v.d = d;
    return v;
  endfunction

  function automatic logic [7:0] dut_p(int i);
    case (i)
      0: return p00;
      1: return p01;
      2: return p02;
      3: return p10;
      4: return p11;
      5: return p12;
      6: return p20;
      7: return p21;
      default: return p22;
    endcase
  endfunction

  function automatic logic [7:0] pix_at(int r, int c);
    int rr, cc;
    rr = r;
    cc = c;
`ifdef NMS_WIN_REPLICATE_EN
    if (rr < 0) rr = 0;
    if (rr >= H) rr = H - 1;
    if (cc < 0) cc = 0;
    if (cc >= W) cc = W - 1;
`else
    if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 8'h00;
`endif
    return img[rr * W + cc];
  endfunction

  task automatic clearObs();
    cap_n = 0; done_n = 0; first_acc = -1; acc_total = 0; low_n = 0;
  endtask

  task automatic modelStep(input logic took, input logic [7:0] px, input logic d);
    int ev, exp_done, k;
    ev = 0; exp_done = 0; k = 0;
    if (ph == 0) begin
      if (took) begin
        img[acc] = px; dimg[acc] = d;
        acc++; acc_total++;
        if (acc >= W + 2) ev = 1;
        if (acc == N) begin ph = 1; fl = 0; end
      end
    end else if (ph == 1) begin
      ev = 1;
      fl++;
      if (fl == W + 1) begin ph = 2; exp_done = 1; end
    end else begin
      ph = 0; acc = 0; next_k = 0;
    end
    checkOutput("win_valid", int'(win_valid), ev);
    checkOutput("frame_done", int'(frame_done), exp_done);
    if (win_valid && cap_n < N) begin
      for (int j = 0; j < 9; j++) cap[cap_n][j] = dut_p(j);
      capd[cap_n] = grad_dir;
      if (cap_n == 0) first_acc = acc_total;
      cap_n++;
    end
    if (frame_done) done_n++;
    if (ev != 0) begin
      k = next_k;
      next_k++;
      for (int j = 0; j < 9; j++)
        checkOutput($sformatf("win%0d_p%0d%0d", k, j / 3, j % 3), int'(dut_p(j)),
                    int'(pix_at(k / W + j / 3 - 1, k % W + j % 3 - 1)));
      checkOutput($sformatf("win%0d_dir", k), int'(grad_dir), int'(dimg[k]));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] px, input logic d,
                               output logic took);
    logic exp_ready;
    @(negedge clk);
    rst = 1'b1; in_valid = v; pix_in = px; dir_in = d;
    #1;
    exp_ready = (ph == 0);
    checkOutput("in_ready", int'(in_ready), int'(exp_ready));
    if (!in_ready) low_n++;
    took = v && exp_ready;
    @(posedge clk);
    #1;
    modelStep(took, px, d);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("in_ready_in_reset", int'(in_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("rst_win_valid", int'(win_valid), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_grad_dir", int'(grad_dir), 0);
    for (int j = 0; j < 9; j++) checkOutput($sformatf("rst_p%0d", j), int'(dut_p(j)), 0);
    ph = 0; acc = 0; fl = 0; next_k = 0;
  endtask

  // mode: 0 ramp, 1 constant 0x10, 2 random; gap: 0 none, 1 toggle, 2 random.
  task automatic runFrame(input int mode, input int gap, input int stop_after);
    logic took, v, d, tog;
    logic [7:0] px;
    int sent, tries;
    sent = 0; tries = 0; tog = 1'b1;
    while (sent < N) begin
      if (stop_after >= 0 && sent == stop_after) begin
        doReset();
        return;
      end
      v = (gap == 0) ? 1'b1 : (gap == 1) ? tog : ($urandom_range(0, 3) != 0);
      tog = ~tog;
      case (mode)
        0: begin px = 8'(sent); d = sent[0]; end
        1: begin px = 8'h10; d = 1'b1; end
        default: begin px = 8'($urandom); d = 1'($urandom); end
      endcase
      applyStimulus(v, px, d, took);
      if (took) sent++;
      tries++;
      if (tries > 20 * N) begin
        n_checks++; n_fail++;
        $display("[TB] FAIL frame_timeout: got %0d pixels expected %0d", sent, N);
        return;
      end
    end
    for (int i = 0; i < W + 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, took);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; pix_in = 8'h00; dir_in = 1'b0;
    ph = 0; acc = 0; fl = 0; next_k = 0;
    clearObs();

`ifdef NMS_WIN_REPLICATE_EN
    tbl[0] = mk(0,  0, 0, 1,  0, 0, 1,  4, 4, 5, 1'b0);
    tbl[1] = mk(3,  2, 3, 3,  2, 3, 3,  6, 7, 7, 1'b1);
    tbl[2] = mk(5,  0, 1, 2,  4, 5, 6,  8, 9, 10, 1'b1);
    tbl[3] = mk(8,  4, 4, 5,  8, 8, 9,  8, 8, 9, 1'b0);
    tbl[4] = mk(11, 6, 7, 7,  10, 11, 11,  10, 11, 11, 1'b1);
`else
    tbl[0] = mk(0,  0, 0, 0,  0, 0, 1,  0, 4, 5, 1'b0);
    tbl[1] = mk(3,  0, 0, 0,  2, 3, 0,  6, 7, 0, 1'b1);
    tbl[2] = mk(5,  0, 1, 2,  4, 5, 6,  8, 9, 10, 1'b1);
    tbl[3] = mk(8,  0, 4, 5,  0, 8, 9,  0, 0, 0, 1'b0);
    tbl[4] = mk(11, 6, 7, 0,  10, 11, 0,  0, 0, 0, 1'b1);
`endif

    doReset();

    // Ramp frame, first streamed then with in_valid toggling every cycle.
    for (int g = 0; g < 2; g++) begin
      clearObs();
      runFrame(0, g, -1);
      checkOutput($sformatf("ramp%0d_win_count", g), cap_n, N);
      checkOutput($sformatf("ramp%0d_done_count", g), done_n, 1);
      checkOutput($sformatf("ramp%0d_ready_low", g), low_n, W + 2);
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 9; j++)
          checkOutput($sformatf("tbl%0d_k%0d_p%0d", g, tbl[i].k, j),
                      int'(cap[tbl[i].k][j]), int'(tbl[i].p[j]));
        checkOutput($sformatf("tbl%0d_k%0d_dir", g, tbl[i].k),
                    int'(capd[tbl[i].k]), int'(tbl[i].d));
      end
    end

    // Constant frame, then a reset partway through a frame followed by a clean frame.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) runFrame(2, 2, 5);
      clearObs();
      runFrame(1, 0, -1);
      checkOutput("const_first_win_acc", first_acc, W + 2);
      checkOutput("const_win_count", cap_n, N);
      checkOutput("const_done_count", done_n, 1);
      for (int j = 0; j < 9; j++)
`ifdef NMS_WIN_REPLICATE_EN
        checkOutput($sformatf("const_w0_p%0d", j), int'(cap[0][j]), 16);
`else
        checkOutput($sformatf("const_w0_p%0d", j), int'(cap[0][j]),
                    (j == 4 || j == 5 || j == 7 || j == 8) ? 16 : 0);
`endif
      checkOutput("const_w0_dir", int'(capd[0]), 1);
    end

    // Random frames with random gaps and occasional mid-frame resets.
    for (int f = 0; f < 8; f++) begin
      clearObs();
      runFrame(2, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
